// File: rtl/window_sum_pkg.sv
// rtl/window_sum_pkg.sv - shared widths for the 5x5 box-sum window stage
package window_sum_pkg;

  localparam int PIX_W  = 8;
  localparam int WIN_N  = 5;
  localparam int COL_W  = PIX_W * WIN_N;
  localparam int CSUM_W = 11;
  localparam int SUM_W  = 13;

endpackage

// File: rtl/column_adder_module.sv
// rtl/column_adder_module.sv - combinational sum of the five pixels in one column
module column_adder_module
  import window_sum_pkg::*;
(
  input  logic [COL_W-1:0]  col,
  output logic [CSUM_W-1:0] sum
);

  // Unsigned add of every byte; 5 x 255 = 1275 fits in CSUM_W bits
  always_comb begin
    sum = '0;
    for (int i = 0; i < WIN_N; i++) begin
      sum = sum + CSUM_W'(col[i*PIX_W +: PIX_W]);
    end
  end

endmodule

// File: rtl/window_sum_module.sv
// rtl/window_sum_module.sv - 5x5 sliding box sum over row-buffer columns with centre tags
module window_sum_module
  import window_sum_pkg::*;
#(
  parameter int IMG_WIDTH = 512,
  parameter int ROWS      = 28
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         col_valid,
  input  logic [COL_W-1:0]             col_in,
  output logic                         win_valid,
  output logic [SUM_W-1:0]             win_sum,
  output logic [$clog2(IMG_WIDTH)-1:0] win_x,
  output logic [$clog2(ROWS)-1:0]      win_row,
  output logic                         frame_done
);

  localparam int X_W = $clog2(IMG_WIDTH);
  localparam int R_W = $clog2(ROWS);

  // First column index at which a full window exists inside the row
  localparam logic [X_W-1:0] X_FIRST_WIN = X_W'(WIN_N - 1);
  localparam logic [X_W-1:0] X_LAST      = X_W'(IMG_WIDTH - 1);
  localparam logic [X_W-1:0] X_HALF      = X_W'(WIN_N / 2);
  localparam logic [R_W-1:0] ROW_LAST    = R_W'(ROWS - 1);

  logic [CSUM_W-1:0] new_cs;
  // Only the four most recent older column sums are ever read; the fifth
  // window column is the one arriving this cycle
  logic [CSUM_W-1:0] cs [0:WIN_N-2];
  logic [X_W-1:0]    x;
  logic [R_W-1:0]    row;
  logic [SUM_W-1:0]  box_sum;

  column_adder_module u_col_adder (
    .col (col_in),
    .sum (new_cs)
  );

  // Window sum = incoming column sum plus the four stored ones (pre-shift)
  always_comb begin
    box_sum = SUM_W'(new_cs);
    for (int i = 0; i < WIN_N - 1; i++) begin
      box_sum = box_sum + SUM_W'(cs[i]);
    end
  end

  // Column-sum shift register; deliberately not cleared at row wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIN_N - 1; i++) begin
        cs[i] <= '0;
      end
    end else if (col_valid) begin
      cs[0] <= new_cs;
      for (int i = 1; i < WIN_N - 1; i++) begin
        cs[i] <= cs[i-1];
      end
    end
  end

  // Column and row position of the accepted column
  always_ff @(posedge clk) begin
    if (rst) begin
      x   <= '0;
      row <= '0;
    end else if (col_valid) begin
      if (x == X_LAST) begin
        x   <= '0;
        row <= (row == ROW_LAST) ? '0 : row + R_W'(1);
      end else begin
        x <= x + X_W'(1);
      end
    end
  end

  // Registered outputs; strobes are single-cycle, data fields hold when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid  <= 1'b0;
      win_sum    <= '0;
      win_x      <= '0;
      win_row    <= '0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (col_valid && (x >= X_FIRST_WIN)) begin
        win_valid  <= 1'b1;
        win_sum    <= box_sum;
        win_x      <= x - X_HALF;
        win_row    <= row;
        frame_done <= (x == X_LAST) && (row == ROW_LAST);
      end
    end
  end

endmodule

// File: tb/tb_window_sum_module.sv
// tb/tb_window_sum_module.sv - randomized self-checking bench for window_sum_module
module tb_window_sum_module;

  localparam int W  = 8;
  localparam int R  = 2;
  localparam int XW = $clog2(W);
  localparam int RW = $clog2(R);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          col_valid = 1'b0;
  logic [39:0]   col_in = '0;
  logic          win_valid;
  logic [12:0]   win_sum;
  logic [XW-1:0] win_x;
  logic [RW-1:0] win_row;
  logic          frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_x, m_row;
  int hist [W];
  int e_valid, e_sum, e_x, e_row, e_fd;

  window_sum_module #(.IMG_WIDTH(W), .ROWS(R)) dut (
    .clk        (clk),
    .rst        (rst),
    .col_valid  (col_valid),
    .col_in     (col_in),
    .win_valid  (win_valid),
    .win_sum    (win_sum),
    .win_x      (win_x),
    .win_row    (win_row),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_x = 0; m_row = 0;
    e_valid = 0; e_sum = 0; e_x = 0; e_row = 0; e_fd = 0;
  endtask

  // Window = plain sum of all 25 bytes of the last five columns in this row
  task automatic model_step(input bit v, input logic [39:0] c);
    int s;
    e_valid = 0;
    e_fd    = 0;
    if (v) begin
      s = 0;
      for (int i = 0; i < 5; i++) s += int'(c[i*8 +: 8]);
      hist[m_x] = s;
      if (m_x >= 4) begin
        e_valid = 1;
        e_sum = 0;
        for (int k = m_x - 4; k <= m_x; k++) e_sum += hist[k];
        e_x   = m_x - 2;
        e_row = m_row;
        e_fd  = (m_x == W - 1 && m_row == R - 1) ? 1 : 0;
      end
      if (m_x == W - 1) begin
        m_x = 0;
        m_row = (m_row == R - 1) ? 0 : m_row + 1;
      end else begin
        m_x++;
      end
    end
  endtask

  // Drive one cycle of stimulus and update the model; outputs sampled 1 after the edge
  task automatic clock_in(input bit v, input logic [39:0] c);
    col_valid = v;
    col_in    = v ? c : 40'bz;
    model_step(v, c);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    col_valid = 1'b1;
    col_in = 40'({$urandom(), $urandom()});
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({win_valid, win_sum, win_x, win_row, frame_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0d s=%0d x=%0d r=%0d fd=%0d, need all 0",
               win_valid, win_sum, win_x, win_row, frame_done);
    end
    rst = 1'b0;
    col_valid = 1'b0;
    model_reset();
  endtask

  task automatic test_ones();
    int nwin [R];
    int nfd;
    nwin[0] = 0; nwin[1] = 0; nfd = 0;
    for (int i = 0; i < W * R; i++) begin
      clock_in(1'b1, 40'h0101010101);
      n_checks++;
      if ({win_valid, win_sum, win_x, win_row, frame_done} !==
          {e_valid[0], e_sum[12:0], e_x[XW-1:0], e_row[RW-1:0], e_fd[0]}) begin
        n_fail++;
        $display("FAIL ones_col%0d: got v=%0d s=%0d x=%0d r=%0d fd=%0d, need v=%0d s=%0d x=%0d r=%0d fd=%0d",
                 i, win_valid, win_sum, win_x, win_row, frame_done, e_valid, e_sum, e_x, e_row, e_fd);
      end
      if (win_valid === 1'b1) begin
        nwin[win_row]++;
        n_checks++;
        if (win_sum !== 13'd25 || int'(win_x) != (i % W) - 2) begin
          n_fail++;
          $display("FAIL ones_value%0d: got s=%0d x=%0d, need s=25 x=%0d", i, win_sum, win_x, (i % W) - 2);
        end
      end
      if (frame_done === 1'b1) nfd++;
    end
    n_checks++;
    if (nwin[0] != 4 || nwin[1] != 4 || nfd != 1) begin
      n_fail++;
      $display("FAIL ones_counts: got row0=%0d row1=%0d fd=%0d, need 4 4 1", nwin[0], nwin[1], nfd);
    end
  endtask

  task automatic test_max();
    for (int i = 0; i < W * R; i++) begin
      clock_in(1'b1, 40'hFFFFFFFFFF);
      n_checks++;
      if ({win_valid, win_sum, win_x, win_row, frame_done} !==
          {e_valid[0], e_sum[12:0], e_x[XW-1:0], e_row[RW-1:0], e_fd[0]} ||
          (win_valid === 1'b1 && win_sum !== 13'd6375)) begin
        n_fail++;
        $display("FAIL max_col%0d: got v=%0d s=%0d x=%0d r=%0d, need v=%0d s=%0d x=%0d r=%0d",
                 i, win_valid, win_sum, win_x, win_row, e_valid, e_sum, e_x, e_row);
      end
    end
  endtask

  task automatic test_ramp_gaps();
    logic [7:0] b;
    for (int i = 0; i < W * R; i++) begin
      b = 8'(i % W);
      clock_in(1'b1, {5{b}});
      n_checks++;
      if ({win_valid, win_sum, win_x, win_row, frame_done} !==
          {e_valid[0], e_sum[12:0], e_x[XW-1:0], e_row[RW-1:0], e_fd[0]} ||
          (win_valid === 1'b1 && int'(win_sum) != 25 * int'(b) - 50)) begin
        n_fail++;
        $display("FAIL ramp_col%0d: got v=%0d s=%0d x=%0d, need v=%0d s=%0d x=%0d",
                 i, win_valid, win_sum, win_x, e_valid, e_sum, e_x);
      end
      for (int g = $urandom_range(1, 3); g > 0; g--) begin
        clock_in(1'b0, '0);
        n_checks++;
        if ({win_valid, win_sum, win_x, win_row, frame_done} !==
            {1'b0, e_sum[12:0], e_x[XW-1:0], e_row[RW-1:0], 1'b0}) begin
          n_fail++;
          $display("FAIL ramp_idle%0d: got v=%0d s=%0d x=%0d fd=%0d, need v=0 s=%0d x=%0d fd=0",
                   i, win_valid, win_sum, win_x, frame_done, e_sum, e_x);
        end
      end
    end
  endtask

  task automatic test_row_boundary();
    for (int i = 0; i < W * R; i++) begin
      clock_in(1'b1, (i < W) ? 40'h0101010101 : 40'h0202020202);
      n_checks++;
      if ({win_valid, win_sum, win_x, win_row, frame_done} !==
          {e_valid[0], e_sum[12:0], e_x[XW-1:0], e_row[RW-1:0], e_fd[0]} ||
          (i >= W && i < W + 4 && win_valid !== 1'b0) ||
          (win_valid === 1'b1 && win_sum !== ((i < W) ? 13'd25 : 13'd50))) begin
        n_fail++;
        $display("FAIL boundary_col%0d: got v=%0d s=%0d x=%0d r=%0d, need v=%0d s=%0d x=%0d r=%0d",
                 i, win_valid, win_sum, win_x, win_row, e_valid, e_sum, e_x, e_row);
      end
    end
  endtask

  task automatic test_random();
    bit v;
    logic [39:0] c;
    for (int i = 0; i < 200; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = 40'({$urandom(), $urandom()});
      clock_in(v, c);
      n_checks++;
      if ({win_valid, win_sum, win_x, win_row, frame_done} !==
          {e_valid[0], e_sum[12:0], e_x[XW-1:0], e_row[RW-1:0], e_fd[0]}) begin
        n_fail++;
        $display("FAIL random_cyc%0d: got v=%0d s=%0d x=%0d r=%0d fd=%0d, need v=%0d s=%0d x=%0d r=%0d fd=%0d",
                 i, win_valid, win_sum, win_x, win_row, frame_done, e_valid, e_sum, e_x, e_row, e_fd);
      end
    end
  endtask

  task automatic test_mid_reset();
    int fd_at;
    int nfd;
    for (int i = 0; i < W + 3; i++) clock_in(1'b1, 40'h0303030303);
    rst = 1'b1;
    col_valid = 1'b1;
    col_in = 40'h0505050505;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    n_checks++;
    if ({win_valid, win_sum, win_x, win_row, frame_done} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got v=%0d s=%0d x=%0d r=%0d fd=%0d, need all 0",
               win_valid, win_sum, win_x, win_row, frame_done);
    end
    fd_at = -1; nfd = 0;
    for (int i = 0; i < W * R; i++) begin
      clock_in(1'b1, 40'h0101010101);
      n_checks++;
      if ({win_valid, win_sum, win_x, win_row, frame_done} !==
          {e_valid[0], e_sum[12:0], e_x[XW-1:0], e_row[RW-1:0], e_fd[0]}) begin
        n_fail++;
        $display("FAIL midreset_col%0d: got v=%0d s=%0d x=%0d r=%0d fd=%0d, need v=%0d s=%0d x=%0d r=%0d fd=%0d",
                 i, win_valid, win_sum, win_x, win_row, frame_done, e_valid, e_sum, e_x, e_row, e_fd);
      end
      if (frame_done === 1'b1) begin
        nfd++;
        fd_at = i;
      end
    end
    n_checks++;
    if (nfd != 1 || fd_at != W * R - 1) begin
      n_fail++;
      $display("FAIL midreset_frame_done: got count=%0d at col %0d, need count=1 at col %0d", nfd, fd_at, W * R - 1);
    end
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_ones();
    test_max();
    test_ramp_gaps();
    test_row_boundary();
    test_random();
    test_mid_reset();
    test_reset();
    test_ones();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
